// File: rtl/cache_pkg.sv
// Shared definitions for the tag/valid lookup and refill controller.
// The FLUSH state exists only when CACHE_TAGV_FLUSH_EN is defined.
package cache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int TAG_W      = 23;
    localparam int ENTRY_W    = 24;
    localparam int VALID_BIT  = 23;
    localparam int IDX_W      = 5;
    localparam int BEAT_W     = 2;
    localparam int OFF_LSB    = 2;
    localparam int IDX_LSB    = 4;
    localparam int TAG_LSB    = 9;
    localparam int LINE_W     = 32 - IDX_LSB;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEM_REQ = 3'd2,
        S_REFILL  = 3'd3,
`ifdef CACHE_TAGV_FLUSH_EN
        S_UPDATE  = 3'd4,
        S_FLUSH   = 3'd5
`else
        S_UPDATE  = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/cache_tag_cmp.sv
// Combinational {valid,tag} compare of one tag-array entry.
// Produces the hit flag used by the LOOKUP state.
module cache_tag_cmp
    import cache_pkg::*;
(
    input  logic [ENTRY_W-1:0] entry,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit
);

    assign hit = entry[VALID_BIT] && (entry[TAG_W-1:0] == tag);

endmodule

// File: rtl/cache_tagv_refill_ctrl.sv
// Tag/valid lookup and 4-word line refill controller.
// Define CACHE_TAGV_FLUSH_EN to add flush_req/flush_busy and a 32-cycle FLUSH.
module cache_tagv_refill_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_valid,
    input  logic [31:0]        cpu_req_addr,
    output logic               cpu_req_ready,
    output logic               cpu_rsp_valid,
    output logic               cpu_rsp_hit,
    output logic [IDX_W-1:0]   tag_a,
    output logic               tag_we,
    output logic [ENTRY_W-1:0] tag_d,
    output logic [IDX_W-1:0]   tag_a_2,
    input  logic [ENTRY_W-1:0] tag_spo_2,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [31:0]        mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [31:0]        mem_rsp_data,
`ifdef CACHE_TAGV_FLUSH_EN
    input  logic               flush_req,
    output logic               flush_busy,
`endif
    output logic               dram_we,
    output logic [6:0]         dram_waddr,
    output logic [31:0]        dram_wdata
);

    state_t              state_q;
    state_t              state_d;
    logic [LINE_W-1:0]   line_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                accept;
    logic                unused_ok;

    assign idx       = line_q[IDX_W-1:0];
    assign tag       = line_q[LINE_W-1:IDX_W];
    assign accept    = (state_q == S_IDLE) && cpu_req_valid && cpu_req_ready;
    assign unused_ok = &{1'b0, cpu_req_addr[IDX_LSB-1:0]};

    cache_tag_cmp u_cmp (
        .entry (tag_spo_2),
        .tag   (tag),
        .hit   (hit)
    );

`ifdef CACHE_TAGV_FLUSH_EN
    logic [IDX_W-1:0] flush_idx_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != S_FLUSH) begin
            flush_idx_q <= '0;
        end else begin
            flush_idx_q <= flush_idx_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                line_q <= cpu_req_addr[31:IDX_LSB];
            end
            if (state_q == S_REFILL && mem_rsp_valid) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        cpu_rsp_hit   = 1'b0;
        tag_a         = '0;
        tag_we        = 1'b0;
        tag_d         = '0;
        tag_a_2       = idx;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        dram_we       = 1'b0;
        dram_waddr    = '0;
        dram_wdata    = '0;
`ifdef CACHE_TAGV_FLUSH_EN
        flush_busy    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef CACHE_TAGV_FLUSH_EN
                cpu_req_ready = !flush_req;
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (cpu_req_valid) begin
                    tag_a_2 = cpu_req_addr[TAG_LSB-1:IDX_LSB];
                    state_d = S_LOOKUP;
                end
`else
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    tag_a_2 = cpu_req_addr[TAG_LSB-1:IDX_LSB];
                    state_d = S_LOOKUP;
                end
`endif
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu_rsp_valid = 1'b1;
                    cpu_rsp_hit   = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {line_q, 4'b0000};
                if (mem_req_ready) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rsp_valid) begin
                    dram_we    = 1'b1;
                    dram_waddr = {idx, beat_q};
                    dram_wdata = mem_rsp_data;
                    if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                        state_d = S_UPDATE;
                    end
                end
            end
            // valid is set only here, after the last data beat has landed
            S_UPDATE: begin
                tag_we        = 1'b1;
                tag_a         = idx;
                tag_d         = {1'b1, tag};
                cpu_rsp_valid = 1'b1;
                state_d       = S_IDLE;
            end
`ifdef CACHE_TAGV_FLUSH_EN
            S_FLUSH: begin
                tag_we     = 1'b1;
                tag_a      = flush_idx_q;
                flush_busy = 1'b1;
                if (flush_idx_q == '1) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_tagv_refill_ctrl.sv
// Directed bench: hit/miss/refill, stalls and gaps, reset mid-refill.
// Also exercises FLUSH when CACHE_TAGV_FLUSH_EN is defined.
module tb_cache_tagv_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_ready;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_hit;
    logic [4:0]  tag_a;
    logic        tag_we;
    logic [23:0] tag_d;
    logic [4:0]  tag_a_2;
    logic [23:0] tag_spo_2 = '0;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        dram_we;
    logic [6:0]  dram_waddr;
    logic [31:0] dram_wdata;
`ifdef CACHE_TAGV_FLUSH_EN
    logic        flush_req;
    logic        flush_busy;
`endif

    logic [23:0] tag_mem [32] = '{default: '0};
    int n_cmp = 0;
    int n_err = 0;
    int dram_cnt = 0;
    int tag_cnt = 0;

    always #5 clk = ~clk;

    cache_tagv_refill_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_ready (cpu_req_ready),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_hit   (cpu_rsp_hit),
        .tag_a         (tag_a),
        .tag_we        (tag_we),
        .tag_d         (tag_d),
        .tag_a_2       (tag_a_2),
        .tag_spo_2     (tag_spo_2),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
`ifdef CACHE_TAGV_FLUSH_EN
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
`endif
        .dram_we       (dram_we),
        .dram_waddr    (dram_waddr),
        .dram_wdata    (dram_wdata)
    );

    // tag array model: synchronous write, one-cycle registered lookup
    always @(posedge clk) begin
        if (tag_we) tag_mem[tag_a] <= tag_d;
        tag_spo_2 <= tag_mem[tag_a_2];
        if (dram_we) dram_cnt++;
        if (tag_we) tag_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // present one request, then check the LOOKUP cycle
    task automatic lookup(input logic [31:0] a, input logic exp_hit);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        #1;
        chk("req_ready", 32'(cpu_req_ready), 32'd1);
        chk("tag_a_2", 32'(tag_a_2), 32'(a[8:4]));
        chk("rsp_early", 32'(cpu_rsp_valid), 32'd0);
        tick();
        cpu_req_valid = 1'b0;
        cpu_req_addr  = 32'h0;
        #1;
        chk("lk_rsp_valid", 32'(cpu_rsp_valid), 32'(exp_hit));
        chk("lk_rsp_hit", 32'(cpu_rsp_hit), 32'(exp_hit));
        chk("lk_ready", 32'(cpu_req_ready), 32'd0);
        chk("lk_memreq", 32'(mem_req_valid), 32'd0);
        tick();
        #1;
        if (exp_hit) begin
            chk("hit_idle_ready", 32'(cpu_req_ready), 32'd1);
            chk("hit_no_memreq", 32'(mem_req_valid), 32'd0);
            chk("hit_rsp_clr", 32'(cpu_rsp_valid), 32'd0);
        end else begin
            chk("miss_memreq", 32'(mem_req_valid), 32'd1);
        end
    endtask

    // entered in MEM_REQ; runs the line fetch through UPDATE back to IDLE
    task automatic refill(input logic [31:0] a, input logic [31:0] base,
                          input int rdy_delay, input int gap);
        int w0;
        int t0;
        w0 = dram_cnt;
        t0 = tag_cnt;
        for (int i = 0; i < rdy_delay; i++) begin
            chk("mreq_hold_v", 32'(mem_req_valid), 32'd1);
            chk("mreq_hold_a", mem_req_addr, {a[31:4], 4'h0});
            tick();
            #1;
        end
        mem_req_ready = 1'b1;
        #1;
        chk("mreq_valid", 32'(mem_req_valid), 32'd1);
        chk("mreq_addr", mem_req_addr, {a[31:4], 4'h0});
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 32'(b);
            #1;
            chk("dram_we", 32'(dram_we), 32'd1);
            chk("dram_waddr", 32'(dram_waddr), 32'({a[8:4], 2'(b)}));
            chk("dram_wdata", dram_wdata, base + 32'(b));
            chk("refill_no_tagwe", 32'(tag_we), 32'd0);
            tick();
            mem_rsp_valid = 1'b0;
            if (b < 3) begin
                for (int g = 0; g < gap; g++) begin
                    #1;
                    chk("gap_dram_we", 32'(dram_we), 32'd0);
                    tick();
                end
            end
        end
        #1;
        chk("upd_tag_we", 32'(tag_we), 32'd1);
        chk("upd_tag_a", 32'(tag_a), 32'(a[8:4]));
        chk("upd_tag_d", 32'(tag_d), {8'h0, 1'b1, a[31:9]});
        chk("upd_rsp_valid", 32'(cpu_rsp_valid), 32'd1);
        chk("upd_rsp_hit", 32'(cpu_rsp_hit), 32'd0);
        chk("dram_writes", 32'(dram_cnt - w0), 32'd4);
        tick();
        #1;
        chk("post_tag_we", 32'(tag_we), 32'd0);
        chk("post_tag_d", 32'(tag_d), 32'd0);
        chk("post_ready", 32'(cpu_req_ready), 32'd1);
        chk("tag_writes", 32'(tag_cnt - t0), 32'd1);
    endtask

    initial begin
        int t0;
        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
`ifdef CACHE_TAGV_FLUSH_EN
        flush_req     = 1'b0;
`endif
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("rst_rsp", 32'(cpu_rsp_valid), 32'd0);
        chk("rst_tag_we", 32'(tag_we), 32'd0);
        chk("rst_tag_d", 32'(tag_d), 32'd0);
        chk("rst_memreq", 32'(mem_req_valid), 32'd0);
        chk("rst_memaddr", mem_req_addr, 32'd0);
        chk("rst_dram_we", 32'(dram_we), 32'd0);
        chk("rst_tag_a_2", 32'(tag_a_2), 32'd0);
        rst = 1'b0;

        // cold miss, index 3, tag 9
        lookup(32'h0000_1230, 1'b0);
        refill(32'h0000_1230, 32'h0000_0AA0, 0, 0);
        // same line, other offset: hit
        lookup(32'h0000_1234, 1'b1);
        // same index, tag 0x19 replaces entry 3
        lookup(32'h0000_3230, 1'b0);
        refill(32'h0000_3230, 32'h0000_0CC0, 0, 0);
        lookup(32'h0000_3230, 1'b1);
        // stalled request and gapped beats, index 7
        lookup(32'h0000_5670, 1'b0);
        refill(32'h0000_5670, 32'h0000_0BB0, 5, 2);
        lookup(32'h0000_5678, 1'b1);

        // reset after beat 2 of a refill, index 4
        lookup(32'h0000_8A40, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDD0 + 32'(b);
            #1;
            chk("r5_dram_waddr", 32'(dram_waddr), 32'({5'd4, 2'(b)}));
            tick();
        end
        mem_rsp_valid = 1'b0;
        t0  = tag_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDD3;
        #1;
        chk("r5_stray_beat", 32'(dram_we), 32'd0);
        chk("r5_idle_ready", 32'(cpu_req_ready), 32'd1);
        chk("r5_no_tag_we", 32'(tag_we), 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        chk("r5_tag_writes", 32'(tag_cnt - t0), 32'd0);
        lookup(32'h0000_8A40, 1'b0);
        refill(32'h0000_8A40, 32'h0000_0EE0, 0, 1);
        lookup(32'h0000_8A40, 1'b1);

`ifdef CACHE_TAGV_FLUSH_EN
        flush_req     = 1'b1;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h0000_1230;
        #1;
        chk("fl_prio_ready", 32'(cpu_req_ready), 32'd0);
        tick();
        flush_req     = 1'b0;
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("fl_tag_we", 32'(tag_we), 32'd1);
            chk("fl_tag_a", 32'(tag_a), 32'(i));
            chk("fl_tag_d", 32'(tag_d), 32'd0);
            chk("fl_busy", 32'(flush_busy), 32'd1);
            chk("fl_ready", 32'(cpu_req_ready), 32'd0);
            tick();
        end
        #1;
        chk("fl_done_busy", 32'(flush_busy), 32'd0);
        chk("fl_done_ready", 32'(cpu_req_ready), 32'd1);
        lookup(32'h0000_3230, 1'b0);
        refill(32'h0000_3230, 32'h0000_0FF0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
